// File: rtl/hazard_stall_unit.sv
// Load-use stall / branch flush / memory freeze controller for a 5-stage pipeline.
// Optional stall-cycle counter (stall_cnt_o) is built only when HAZARD_STALL_CNT_EN is defined.
module hazard_stall_unit #(
   parameter int CNT_W = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mem_read_IDEX_i,
   input  logic [4:0] Rt_IDEX_i,
   input  logic [4:0] Rs_IFID_i,
   input  logic [4:0] Rt_IFID_i,
   input  logic       uses_rt_IFID_i,
   input  logic       branch_taken_EX_i,
   input  logic       mem_busy_i,
   output logic       pc_write_o,
   output logic       ifid_write_o,
   output logic       idex_bubble_o,
   output logic       ifid_flush_o,
   output logic       idex_flush_o,
   output logic [1:0] state_o
`ifdef HAZARD_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt_o
`endif
);

   localparam logic [1:0] RUN        = 2'b00;
   localparam logic [1:0] LOAD_STALL = 2'b01;
   localparam logic [1:0] FLUSH      = 2'b10;
   localparam logic [1:0] FREEZE     = 2'b11;

   logic [1:0] state;
   logic [1:0] next_state;
   logic [1:0] saved_state;
   logic [1:0] eval_state;
   logic       load_use;

   assign load_use = mem_read_IDEX_i && (Rt_IDEX_i != 5'd0) &&
                     ((Rt_IDEX_i == Rs_IFID_i) ||
                      (uses_rt_IFID_i && (Rt_IDEX_i == Rt_IFID_i)));

   // On release from FREEZE the inputs are judged as if still in the pre-freeze state.
   assign eval_state = (state == FREEZE) ? saved_state : state;
   assign state_o    = state;

   always_comb begin
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      idex_bubble_o = 1'b0;
      ifid_flush_o  = 1'b0;
      idex_flush_o  = 1'b0;
      next_state    = RUN;
      if (!reset) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_bubble_o = 1'b1;
      end else if (mem_busy_i) begin
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
         next_state   = FREEZE;
      end else begin
         case (eval_state)
            RUN, LOAD_STALL: begin
               if (branch_taken_EX_i) begin
                  ifid_flush_o = 1'b1;
                  idex_flush_o = 1'b1;
                  next_state   = FLUSH;
               end else if ((eval_state == RUN) && load_use) begin
                  pc_write_o    = 1'b0;
                  ifid_write_o  = 1'b0;
                  idex_bubble_o = 1'b1;
                  next_state    = LOAD_STALL;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= RUN;
         saved_state <= RUN;
      end else begin
         state <= next_state;
         if (mem_busy_i && (state != FREEZE))
            saved_state <= state;
      end
   end

`ifdef HAZARD_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (!reset)
         stall_cnt_o <= '0;
      else if (!pc_write_o && (stall_cnt_o != '1))
         stall_cnt_o <= stall_cnt_o + 1'b1;
   end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: expected output vectors are queued as stimulus
// is driven and compared while the Mealy outputs settle, before the next rising edge.
module tb_hazard_stall_unit;

   typedef struct packed {
      logic       rst;
      logic       mr;
      logic [4:0] rt_ex;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       ur;
      logic       br;
      logic       busy;
      logic [6:0] exp;  // {pc_write, ifid_write, bubble, ifid_flush, idex_flush, state[1:0]}
   } vec_t;

   logic       clk;
   logic       reset;
   logic       mem_read_IDEX_i;
   logic [4:0] Rt_IDEX_i;
   logic [4:0] Rs_IFID_i;
   logic [4:0] Rt_IFID_i;
   logic       uses_rt_IFID_i;
   logic       branch_taken_EX_i;
   logic       mem_busy_i;
   logic       pc_write_o;
   logic       ifid_write_o;
   logic       idex_bubble_o;
   logic       ifid_flush_o;
   logic       idex_flush_o;
   logic [1:0] state_o;
`ifdef HAZARD_STALL_CNT_EN
   logic [15:0] stall_cnt;
   logic        sat_pc_write, sat_ifid_write, sat_bubble, sat_ifid_flush, sat_idex_flush;
   logic [1:0]  sat_state;
   logic [3:0]  sat_cnt;
`endif

   int tests_run = 0;
   int tests_failed = 0;
   logic [6:0] exp_q[$];

   hazard_stall_unit #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .mem_read_IDEX_i(mem_read_IDEX_i), .Rt_IDEX_i(Rt_IDEX_i),
      .Rs_IFID_i(Rs_IFID_i), .Rt_IFID_i(Rt_IFID_i), .uses_rt_IFID_i(uses_rt_IFID_i),
      .branch_taken_EX_i(branch_taken_EX_i), .mem_busy_i(mem_busy_i),
      .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .idex_bubble_o(idex_bubble_o),
      .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o), .state_o(state_o)
`ifdef HAZARD_STALL_CNT_EN
      , .stall_cnt_o(stall_cnt)
`endif
   );

`ifdef HAZARD_STALL_CNT_EN
   hazard_stall_unit #(.CNT_W(4)) u_sat (
      .clk(clk), .reset(reset),
      .mem_read_IDEX_i(mem_read_IDEX_i), .Rt_IDEX_i(Rt_IDEX_i),
      .Rs_IFID_i(Rs_IFID_i), .Rt_IFID_i(Rt_IFID_i), .uses_rt_IFID_i(uses_rt_IFID_i),
      .branch_taken_EX_i(branch_taken_EX_i), .mem_busy_i(mem_busy_i),
      .pc_write_o(sat_pc_write), .ifid_write_o(sat_ifid_write), .idex_bubble_o(sat_bubble),
      .ifid_flush_o(sat_ifid_flush), .idex_flush_o(sat_idex_flush), .state_o(sat_state),
      .stall_cnt_o(sat_cnt)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic rst, input logic mr, input logic [4:0] rt_ex,
                               input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                               input logic br, input logic busy, input logic [6:0] exp);
      vec_t v;
      v.rst = rst; v.mr = mr; v.rt_ex = rt_ex; v.rs = rs; v.rt = rt;
      v.ur = ur; v.br = br; v.busy = busy; v.exp = exp;
      return v;
   endfunction

   task automatic drive(input vec_t s);
      reset             = s.rst;
      mem_read_IDEX_i   = s.mr;
      Rt_IDEX_i         = s.rt_ex;
      Rs_IFID_i         = s.rs;
      Rt_IFID_i         = s.rt;
      uses_rt_IFID_i    = s.ur;
      branch_taken_EX_i = s.br;
      mem_busy_i        = s.busy;
   endtask

   task automatic test_reset();
      vec_t v[$];
      logic [6:0] got, exp;
      repeat (2) @(posedge clk);
      v.push_back(mk(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 7'b0010000));
      v.push_back(mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 7'b0010000));
      foreach (v[i]) begin
         @(negedge clk); drive(v[i]); exp_q.push_back(v[i].exp);
         #1;
         got = {pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o, idex_flush_o, state_o};
         exp = exp_q.pop_front();
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL reset[%0d] got=%b expected=%b", i, got, exp);
         end
      end
      @(posedge clk); #1;
`ifdef HAZARD_STALL_CNT_EN
      tests_run++;
      if (stall_cnt !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset_cnt got=%0d expected=0", stall_cnt);
      end
`endif
   endtask

   task automatic test_load_use();
      vec_t v[$];
      logic [6:0] got, exp;
      v.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 7'b1100000));
      v.push_back(mk(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 7'b0010000));
      v.push_back(mk(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 7'b1100001));
      v.push_back(mk(1'b1, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, 7'b1100000));
      v.push_back(mk(1'b1, 1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 7'b0010000));
      v.push_back(mk(1'b1, 1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 7'b1100001));
      v.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 7'b1100000));
      foreach (v[i]) begin
         @(negedge clk); drive(v[i]); exp_q.push_back(v[i].exp);
         #1;
         got = {pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o, idex_flush_o, state_o};
         exp = exp_q.pop_front();
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL load_use[%0d] got=%b expected=%b", i, got, exp);
         end
      end
      @(posedge clk); #1;
`ifdef HAZARD_STALL_CNT_EN
      tests_run++;
      if (stall_cnt !== 16'd2) begin
         tests_failed++;
         $display("FAIL load_use_cnt got=%0d expected=2", stall_cnt);
      end
`endif
   endtask

   task automatic test_zero_reg();
      vec_t v[$];
      logic [6:0] got, exp;
      v.push_back(mk(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 7'b1100000));
      v.push_back(mk(1'b1, 1'b1, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 7'b1100000));
      foreach (v[i]) begin
         @(negedge clk); drive(v[i]); exp_q.push_back(v[i].exp);
         #1;
         got = {pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o, idex_flush_o, state_o};
         exp = exp_q.pop_front();
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL zero_reg[%0d] got=%b expected=%b", i, got, exp);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_branch_priority();
      vec_t v[$];
      logic [6:0] got, exp;
      v.push_back(mk(1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 7'b1101100));
      v.push_back(mk(1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 7'b1100010));
      v.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 7'b1100000));
      v.push_back(mk(1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 7'b0010000));
      v.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 7'b1101101));
      v.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 7'b1100010));
      v.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 7'b1100000));
      foreach (v[i]) begin
         @(negedge clk); drive(v[i]); exp_q.push_back(v[i].exp);
         #1;
         got = {pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o, idex_flush_o, state_o};
         exp = exp_q.pop_front();
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL branch[%0d] got=%b expected=%b", i, got, exp);
         end
      end
      @(posedge clk); #1;
`ifdef HAZARD_STALL_CNT_EN
      tests_run++;
      if (stall_cnt !== 16'd3) begin
         tests_failed++;
         $display("FAIL branch_cnt got=%0d expected=3", stall_cnt);
      end
`endif
   endtask

   task automatic test_freeze();
      vec_t v[$];
      logic [6:0] got, exp;
      v.push_back(mk(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 7'b0010000));
      v.push_back(mk(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 7'b0000001));
      v.push_back(mk(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 7'b0000011));
      v.push_back(mk(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 7'b0000011));
      v.push_back(mk(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 7'b1100011));
      v.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 7'b1100000));
      v.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 7'b0000000));
      v.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 7'b1101111));
      v.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 7'b0000010));
      v.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 7'b1100011));
      v.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 7'b1100000));
      foreach (v[i]) begin
         @(negedge clk); drive(v[i]); exp_q.push_back(v[i].exp);
         #1;
         got = {pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o, idex_flush_o, state_o};
         exp = exp_q.pop_front();
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL freeze[%0d] got=%b expected=%b", i, got, exp);
         end
      end
      @(posedge clk); #1;
`ifdef HAZARD_STALL_CNT_EN
      tests_run++;
      if (stall_cnt !== 16'd9) begin
         tests_failed++;
         $display("FAIL freeze_cnt got=%0d expected=9", stall_cnt);
      end
`endif
   endtask

   task automatic test_back_to_back();
      vec_t v[$];
      logic [6:0] got, exp;
      v.push_back(mk(1'b1, 1'b1, 5'd12, 5'd12, 5'd0, 1'b0, 1'b0, 1'b0, 7'b0010000));
      v.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 7'b1100001));
      v.push_back(mk(1'b1, 1'b1, 5'd31, 5'd1, 5'd31, 1'b1, 1'b0, 1'b0, 7'b0010000));
      v.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 7'b1100001));
      foreach (v[i]) begin
         @(negedge clk); drive(v[i]); exp_q.push_back(v[i].exp);
         #1;
         got = {pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o, idex_flush_o, state_o};
         exp = exp_q.pop_front();
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL back_to_back[%0d] got=%b expected=%b", i, got, exp);
         end
      end
      @(posedge clk); #1;
`ifdef HAZARD_STALL_CNT_EN
      tests_run++;
      if (stall_cnt !== 16'd11) begin
         tests_failed++;
         $display("FAIL back_to_back_cnt got=%0d expected=11", stall_cnt);
      end
`endif
   endtask

   task automatic test_reset_mid();
      vec_t v[$];
      logic [6:0] got, exp;
      v.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 7'b1101100));
      v.push_back(mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 7'b0010010));
      v.push_back(mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 7'b0010000));
      v.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 7'b1100000));
      v.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 7'b0000000));
      v.push_back(mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 7'b0010011));
      v.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 7'b1100000));
      foreach (v[i]) begin
         @(negedge clk); drive(v[i]); exp_q.push_back(v[i].exp);
         #1;
         got = {pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o, idex_flush_o, state_o};
         exp = exp_q.pop_front();
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL reset_mid[%0d] got=%b expected=%b", i, got, exp);
         end
      end
      @(posedge clk); #1;
`ifdef HAZARD_STALL_CNT_EN
      tests_run++;
      if (stall_cnt !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset_mid_cnt got=%0d expected=0", stall_cnt);
      end
`endif
   endtask

   task automatic test_saturation();
      vec_t v[$];
      logic [6:0] got, exp;
      v.push_back(mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 7'b0010000));
      v.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 7'b0000000));
      for (int unsigned k = 1; k < 20; k++)
         v.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 7'b0000011));
      foreach (v[i]) begin
         @(negedge clk); drive(v[i]); exp_q.push_back(v[i].exp);
         #1;
         got = {pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o, idex_flush_o, state_o};
         exp = exp_q.pop_front();
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL saturation[%0d] got=%b expected=%b", i, got, exp);
         end
      end
      @(posedge clk); #1;
`ifdef HAZARD_STALL_CNT_EN
      tests_run++;
      if (stall_cnt !== 16'd20) begin
         tests_failed++;
         $display("FAIL freeze20_cnt got=%0d expected=20", stall_cnt);
      end
      tests_run++;
      if (sat_cnt !== 4'd15) begin
         tests_failed++;
         $display("FAIL sat_cnt got=%0d expected=15", sat_cnt);
      end
`endif
   endtask

   initial begin
      reset = 1'b0; mem_read_IDEX_i = 1'b0; Rt_IDEX_i = '0; Rs_IFID_i = '0;
      Rt_IFID_i = '0; uses_rt_IFID_i = 1'b0; branch_taken_EX_i = 1'b0; mem_busy_i = 1'b0;
      test_reset();
      test_load_use();
      test_zero_reg();
      test_branch_priority();
      test_freeze();
      test_back_to_back();
      test_reset_mid();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
